i2c_mstr_ctrl: RTL

I2C_MSTR_CTRL -- requirements
Module: i2c_mstr_ctrl

---
 rtl/i2c_mstr_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_mstr_ctrl.sv
// Single-byte I2C master: register/direct write and read with repeated START.
// Every bit is four SCL quarters paced by a CLK_DIV clock divider; all pin outputs are registered.
module i2c_mstr_ctrl #(
    parameter int CLK_DIV = 312
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic       cycle,
    input  logic [6:0] devOut,
    input  logic [7:0] addrOut,
    input  logic [7:0] dataOut,
    output logic [7:0] dataIn,
    output logic       bsy,
    output logic       ok,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, DEV, ACK_D, REG, ACK_R, RSTART, DEVR,
        ACK_DR, WDAT, ACK_W, RDAT, MNACK, STOP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_q, w_q_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_rw, r_cycle, r_fail, r_bsy, r_ok;
    logic [6:0]    r_dev;
    logic [7:0]    r_addr, r_wdata, r_shift, r_data_in;
    logic [1:0]    r_sda_sync;
    logic          r_scl_oe, r_sda_oe;
    logic          w_tick, w_accept, w_done, w_sample, w_is_ack;
    logic          w_scl_oe, w_sda_oe;
    logic [7:0]    w_tx_byte;

    assign w_tick   = r_bsy && (r_cnt == DIV_MAX);
    assign w_accept = (r_state == IDLE) && req;
    assign w_done   = w_tick && (r_state == STOP) && (r_q == 2'd3);
    assign w_sample = w_tick && (r_q == 2'd2);
    assign w_is_ack = (r_state == ACK_D) || (r_state == ACK_R) ||
                      (r_state == ACK_DR) || (r_state == ACK_W);

    // Quarter-period divider, free-running only while a transfer is active
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!r_bsy || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // FSM state register with quarter and bit position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= 2'd0;
            r_bit   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Next-state logic: quarters advance on each tick, states change after Q3
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_bit_nxt   = r_bit;
        if (r_state == IDLE) begin
            if (req) begin
                w_state_nxt = START;
                w_q_nxt     = 2'd0;
                w_bit_nxt   = 3'd0;
            end else begin
                w_state_nxt = IDLE;
            end
        end else if (w_tick) begin
            if (r_q != 2'd3) begin
                w_q_nxt = r_q + 2'd1;
            end else begin
                w_q_nxt   = 2'd0;
                w_bit_nxt = 3'd0;
                case (r_state)
                    START:  w_state_nxt = DEV;
                    DEV, REG, DEVR, WDAT, RDAT: begin
                        w_bit_nxt = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            case (r_state)
                                DEV:     w_state_nxt = ACK_D;
                                REG:     w_state_nxt = ACK_R;
                                DEVR:    w_state_nxt = ACK_DR;
                                WDAT:    w_state_nxt = ACK_W;
                                default: w_state_nxt = MNACK;
                            endcase
                        end else begin
                            w_state_nxt = r_state;
                        end
                    end
                    ACK_D: begin
                        if (r_fail)       w_state_nxt = STOP;
                        else if (r_cycle) w_state_nxt = REG;
                        else if (r_rw)    w_state_nxt = RDAT;
                        else              w_state_nxt = WDAT;
                    end
                    ACK_R: begin
                        if (r_fail)    w_state_nxt = STOP;
                        else if (r_rw) w_state_nxt = RSTART;
                        else           w_state_nxt = WDAT;
                    end
                    ACK_DR: begin
                        if (r_fail) w_state_nxt = STOP;
                        else        w_state_nxt = RDAT;
                    end
                    RSTART:        w_state_nxt = DEVR;
                    ACK_W, MNACK:  w_state_nxt = STOP;
                    STOP:          w_state_nxt = IDLE;
                    default:       w_state_nxt = IDLE;
                endcase
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Byte currently being shifted out by the master
    always_comb begin
        w_tx_byte = 8'h00;
        case (r_state)
            DEV:     w_tx_byte = {r_dev, (~r_cycle) & r_rw};
            REG:     w_tx_byte = r_addr;
            DEVR:    w_tx_byte = {r_dev, 1'b1};
            WDAT:    w_tx_byte = r_wdata;
            default: w_tx_byte = 8'h00;
        endcase
    end

    // Pin levels per state and quarter; SCL is held low in Q0 and Q3 of every bit
    always_comb begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
        case (r_state)
            IDLE: begin
                w_scl_oe = 1'b0;
                w_sda_oe = 1'b0;
            end
            START: begin
                w_scl_oe = (r_q == 2'd3);
                w_sda_oe = (r_q != 2'd0);
            end
            DEV, REG, DEVR, WDAT: begin
                w_scl_oe = (r_q == 2'd0) || (r_q == 2'd3);
                w_sda_oe = ~w_tx_byte[3'd7 - r_bit];
            end
            RSTART: begin
                w_scl_oe = (r_q == 2'd0) || (r_q == 2'd3);
                w_sda_oe = r_q[1];
            end
            STOP: begin
                w_scl_oe = (r_q == 2'd0);
                w_sda_oe = ~r_q[1];
            end
            default: begin
                w_scl_oe = (r_q == 2'd0) || (r_q == 2'd3);
                w_sda_oe = 1'b0;
            end
        endcase
    end

    // Request latch, SDA sampling, completion status and registered pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rw       <= 1'b0;
            r_cycle    <= 1'b0;
            r_dev      <= 7'h00;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_shift    <= 8'h00;
            r_fail     <= 1'b0;
            r_bsy      <= 1'b0;
            r_ok       <= 1'b0;
            r_data_in  <= 8'h00;
            r_sda_sync <= 2'b11;
            r_scl_oe   <= 1'b0;
            r_sda_oe   <= 1'b0;
        end else begin
            r_sda_sync <= {r_sda_sync[0], sda_in};
            r_scl_oe   <= w_scl_oe;
            r_sda_oe   <= w_sda_oe;
            if (w_accept) begin
                r_rw    <= rw;
                r_cycle <= cycle;
                r_dev   <= devOut;
                r_addr  <= addrOut;
                r_wdata <= dataOut;
                r_fail  <= 1'b0;
                r_bsy   <= 1'b1;
                r_ok    <= 1'b0;
            end else if (w_done) begin
                r_bsy <= 1'b0;
                r_ok  <= ~r_fail;
                if (!r_fail && r_rw) begin
                    r_data_in <= r_shift;
                end
            end
            if (w_sample && (r_state == RDAT)) begin
                r_shift <= {r_shift[6:0], r_sda_sync[1]};
            end
            // A released SDA during any acknowledge slot is a NACK
            if (w_sample && w_is_ack) begin
                r_fail <= r_fail | r_sda_sync[1];
            end
        end
    end

    assign dataIn = r_data_in;
    assign bsy    = r_bsy;
    assign ok     = r_ok;
    assign scl_oe = r_scl_oe;
    assign sda_oe = r_sda_oe;

endmodule
